// File: rtl/panda_mem_arbiter.sv
// panda_mem_arbiter: shares one single-ported memory bus between the
// instruction-fetch port and the load/store port, one transaction at a time.
module panda_mem_arbiter #(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic [3:0]  data_we_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        spurious_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RESP
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner_data;
    logic [3:0]  r_streak;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_we;
    logic [31:0] r_mem_wdata;
    logic        r_spurious;

    logic        w_any_req;
    logic        w_sat;
    logic        w_pick_data;
    logic        w_start;
    logic        w_in_addr;
    logic        w_in_resp;

    assign w_any_req   = instr_req_i | data_req_i;
    assign w_sat       = (r_streak >= STREAK_MAX);
    // Data wins ties unless it has starved the fetch port long enough.
    assign w_pick_data = data_req_i & ~(instr_req_i & w_sat);
    assign w_start     = (r_state == ST_IDLE) & w_any_req;
    assign w_in_addr   = (r_state == ST_ADDR);
    assign w_in_resp   = (r_state == ST_RESP);

    // State register; reset abandons any outstanding transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: one request, one grant, one response.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_any_req)    w_state_nxt = ST_ADDR;
            ST_ADDR: if (mem_gnt_i)    w_state_nxt = ST_RESP;
            ST_RESP: if (mem_rvalid_i) w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch the winner's attributes and hold them until memory grants.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem_req    <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_we     <= 4'h0;
            r_mem_wdata  <= 32'h0;
            r_owner_data <= 1'b0;
        end else if (w_start) begin
            r_mem_req    <= 1'b1;
            r_owner_data <= w_pick_data;
            if (w_pick_data) begin
                r_mem_addr  <= data_addr_i;
                r_mem_we    <= data_we_i;
                r_mem_wdata <= data_wdata_i;
            end else begin
                r_mem_addr  <= instr_addr_i;
                r_mem_we    <= 4'h0;
                r_mem_wdata <= 32'h0;
            end
        end else if (w_in_addr && mem_gnt_i) begin
            r_mem_req <= 1'b0;
        end
    end

    // Count data wins that left a fetch waiting; any other win clears it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_streak <= 4'h0;
        end else if (w_start) begin
            if (w_pick_data && instr_req_i) begin
                if (!w_sat) begin
                    r_streak <= r_streak + 4'h1;
                end
            end else begin
                r_streak <= 4'h0;
            end
        end
    end

    // Sticky flag for responses that no transaction was waiting for.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_spurious <= 1'b0;
        end else if (mem_rvalid_i && !w_in_resp) begin
            r_spurious <= 1'b1;
        end
    end

    assign mem_req_o      = r_mem_req;
    assign mem_addr_o     = r_mem_addr;
    assign mem_we_o       = r_mem_we;
    assign mem_wdata_o    = r_mem_wdata;
    assign spurious_o     = r_spurious;

    assign instr_gnt_o    = w_in_addr & mem_gnt_i & ~r_owner_data;
    assign data_gnt_o     = w_in_addr & mem_gnt_i & r_owner_data;
    assign instr_rvalid_o = w_in_resp & mem_rvalid_i & ~r_owner_data;
    assign data_rvalid_o  = w_in_resp & mem_rvalid_i & r_owner_data;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_panda_mem_arbiter.sv
// tb_panda_mem_arbiter: scoreboard bench with a simple memory model,
// directed fetch/load/store traffic, wait states and reset cases.
module tb_panda_mem_arbiter;

    logic        clk;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic [31:0] data_addr_i;
    logic [3:0]  data_we_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_we_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        spurious_o;

    logic        a_gnt;
    logic        a_rv;
    logic        m_gnt;
    logic        m_rv;
    logic [31:0] m_rdata;

    assign mem_gnt_i    = a_gnt | m_gnt;
    assign mem_rvalid_i = a_rv | m_rv;
    assign mem_rdata_i  = m_rdata;

    panda_mem_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_addr_i    (data_addr_i),
        .data_we_i      (data_we_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_addr_o     (mem_addr_o),
        .mem_we_o       (mem_we_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .spurious_o     (spurious_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t exp_q[$];
    txn_t rsp_q[$];
    int   checks;
    int   failures;
    bit   outstanding;
    bit   mem_auto;
    int   gnt_dly;
    int   rv_dly;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A5_5A5A);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic d, input logic [31:0] a,
                            input logic [3:0] we, input logic [31:0] wd);
        txn_t t;
        t.is_data = d;
        t.addr    = a;
        t.we      = we;
        t.wdata   = wd;
        t.rdata   = mem_data(a);
        exp_q.push_back(t);
    endtask

    task automatic wait_gnt(input bit is_data);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (is_data ? data_gnt_o : instr_gnt_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL gnt_timeout port=%0d actual=0 required=1", is_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_instr(input logic [31:0] a);
        instr_req_i  = 1'b1;
        instr_addr_i = a;
        wait_gnt(1'b0);
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
    endtask

    task automatic do_data(input logic [31:0] a, input logic [3:0] we,
                           input logic [31:0] wd);
        data_req_i   = 1'b1;
        data_addr_i  = a;
        data_we_i    = we;
        data_wdata_i = wd;
        wait_gnt(1'b1);
        data_req_i   = 1'b0;
        data_addr_i  = 32'h0;
        data_we_i    = 4'h0;
        data_wdata_i = 32'h0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && rsp_q.size() == 0 &&
                !outstanding && !mem_req_o) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
        @(posedge clk);
        #1;
    endtask

    // Memory model: grant after gnt_dly cycles, respond rv_dly cycles later.
    initial begin
        logic [31:0] a;
        a_gnt   = 1'b0;
        a_rv    = 1'b0;
        m_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto && mem_req_o && !rst_i) begin
                repeat (gnt_dly) begin
                    @(posedge clk);
                    #1;
                end
                a_gnt = 1'b1;
                a     = mem_addr_o;
                @(posedge clk);
                #1;
                a_gnt = 1'b0;
                repeat (rv_dly - 1) begin
                    @(posedge clk);
                    #1;
                end
                a_rv    = 1'b1;
                m_rdata = mem_data(a);
                @(posedge clk);
                #1;
                a_rv = 1'b0;
            end
        end
    end

    // Monitor: checks grants against the expected order and responses
    // against the outstanding transaction.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (mem_req_o) begin
                    chk("req_while_outstanding", {31'b0, outstanding}, 32'h0);
                    if (exp_q.size() > 0)
                        chk("mem_addr_stable", mem_addr_o, exp_q[0].addr);
                end
                if (mem_req_o && mem_gnt_i) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_grant actual=%b%b required=none",
                                 instr_gnt_o, data_gnt_o);
                    end else begin
                        t = exp_q.pop_front();
                        chk("mem_addr", mem_addr_o, t.addr);
                        chk("mem_we", {28'b0, mem_we_o}, {28'b0, t.we});
                        chk("mem_wdata", mem_wdata_o, t.wdata);
                        chk("instr_gnt", {31'b0, instr_gnt_o}, {31'b0, ~t.is_data});
                        chk("data_gnt", {31'b0, data_gnt_o}, {31'b0, t.is_data});
                        rsp_q.push_back(t);
                        outstanding = 1'b1;
                    end
                end else if (instr_gnt_o || data_gnt_o) begin
                    checks++;
                    failures++;
                    $display("FAIL stray_gnt actual=%b%b required=00",
                             instr_gnt_o, data_gnt_o);
                end
                if (instr_rvalid_o || data_rvalid_o) begin
                    if (rsp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rvalid actual=%b%b required=00",
                                 instr_rvalid_o, data_rvalid_o);
                    end else begin
                        t = rsp_q.pop_front();
                        chk("instr_rvalid", {31'b0, instr_rvalid_o}, {31'b0, ~t.is_data});
                        chk("data_rvalid", {31'b0, data_rvalid_o}, {31'b0, t.is_data});
                        chk("rdata", t.is_data ? data_rdata_o : instr_rdata_o, t.rdata);
                        outstanding = 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_req"}, {31'b0, mem_req_o}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
        chk({tag, "_mem_we"}, {28'b0, mem_we_o}, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
        chk({tag, "_gnts"}, {30'b0, instr_gnt_o, data_gnt_o}, 32'h0);
        chk({tag, "_rvalids"}, {30'b0, instr_rvalid_o, data_rvalid_o}, 32'h0);
        chk({tag, "_spurious"}, {31'b0, spurious_o}, 32'h0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        outstanding  = 1'b0;
        mem_auto     = 1'b0;
        gnt_dly      = 0;
        rv_dly       = 1;
        m_gnt        = 1'b0;
        m_rv         = 1'b0;
        rst_i        = 1'b1;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_addr_i  = 32'h0;
        data_we_i    = 4'h0;
        data_wdata_i = 32'h0;

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_i = 1'b0;
        @(posedge clk);
        #1;

        // Stray response in IDLE sets the sticky flag.
        m_rv = 1'b1;
        @(posedge clk);
        #1;
        m_rv = 1'b0;
        chk("spurious_idle", {31'b0, spurious_o}, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        chk("spurious_sticky", {31'b0, spurious_o}, 32'h1);

        // Single fetch, grant one cycle after request.
        mem_auto = 1'b1;
        gnt_dly  = 1;
        rv_dly   = 1;
        push_exp(1'b0, 32'h100, 4'h0, 32'h0);
        do_instr(32'h100);
        wait_idle();

        // Store, zero-wait memory, then a load.
        gnt_dly = 0;
        push_exp(1'b1, 32'h2000, 4'hF, 32'h12345678);
        do_data(32'h2000, 4'hF, 32'h12345678);
        wait_idle();
        push_exp(1'b1, 32'h2004, 4'h0, 32'h0);
        do_data(32'h2004, 4'h0, 32'h0);
        wait_idle();

        // Both ports busy: D D D D I D D D D I.
        for (int k = 0; k < 4; k++)
            push_exp(1'b1, 32'h3000 + 32'(4 * k), 4'(k & 1) * 4'h3, 32'h1000 + 32'(k));
        push_exp(1'b0, 32'h400, 4'h0, 32'h0);
        for (int k = 4; k < 8; k++)
            push_exp(1'b1, 32'h3000 + 32'(4 * k), 4'(k & 1) * 4'h3, 32'h1000 + 32'(k));
        push_exp(1'b0, 32'h404, 4'h0, 32'h0);
        fork
            begin
                for (int k = 0; k < 8; k++)
                    do_data(32'h3000 + 32'(4 * k), 4'(k & 1) * 4'h3, 32'h1000 + 32'(k));
            end
            begin
                do_instr(32'h400);
                do_instr(32'h404);
            end
        join
        wait_idle();

        // Wait states; a fetch arriving during ADDR must wait its turn.
        gnt_dly = 3;
        rv_dly  = 2;
        push_exp(1'b1, 32'h2400, 4'h0, 32'h0);
        push_exp(1'b0, 32'h600, 4'h0, 32'h0);
        fork
            do_data(32'h2400, 4'h0, 32'h0);
            begin
                repeat (2) @(posedge clk);
                #1;
                do_instr(32'h600);
            end
        join
        wait_idle();
        chk("spurious_kept", {31'b0, spurious_o}, 32'h1);

        // Reset during RESP drops the response; late rvalid is spurious.
        mem_auto = 1'b0;
        gnt_dly  = 0;
        rv_dly   = 1;
        push_exp(1'b0, 32'h500, 4'h0, 32'h0);
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h500;
        @(posedge clk);
        #1;
        m_gnt = 1'b1;
        @(posedge clk);
        #1;
        m_gnt        = 1'b0;
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        @(negedge clk);
        chk("pre_reset_resp", {31'b0, outstanding}, 32'h1);
        rsp_q.delete();
        outstanding = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        m_rv = 1'b1;
        @(posedge clk);
        #1;
        m_rv = 1'b0;
        chk("spurious_after_reset", {31'b0, spurious_o}, 32'h1);

        // Normal traffic still works afterwards.
        mem_auto = 1'b1;
        push_exp(1'b1, 32'h2800, 4'h0, 32'h0);
        do_data(32'h2800, 4'h0, 32'h0);
        wait_idle();

        chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/panda_mem_arbiter.md
# panda_mem_arbiter

Shares one single-ported memory bus between the instruction-fetch port and the load/store port of the panda core, so the core can run from a unified memory. It uses a request/grant/response handshake with at most one outstanding transaction. Data requests win by default. A streak counter guarantees instruction-fetch progress. The block sits between the core's instruction and data interfaces and the external memory.

## Interface
- MAX_DATA_STREAK, 4: maximum number of consecutive data grants while an instruction request waits; range 1..15.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- instr_req_i  in  1  fetch request; held with a stable address until instr_gnt_o.
- instr_addr_i  in  32  fetch address.
- instr_gnt_o  out  1  one-cycle pulse: the fetch was accepted by memory.
- instr_rvalid_o  out  1  fetch data valid on instr_rdata_o.
- instr_rdata_o  out  32  fetch data.
- data_req_i  in  1  load/store request; held with stable attributes until data_gnt_o.
- data_addr_i  in  32  load/store address.
- data_we_i  in  4  byte write enables; 0 means read.
- data_wdata_i  in  32  store data.
- data_gnt_o  out  1  one-cycle pulse: the load/store was accepted.
- data_rvalid_o  out  1  response valid; also issued for stores.
- data_rdata_o  out  32  load data.
- mem_req_o  out  1  memory request, registered.
- mem_addr_o  out  32  registered address.
- mem_we_o  out  4  registered byte enables.
- mem_wdata_o  out  32  registered store data.
- mem_gnt_i  in  1  memory accepted the request.
- mem_rvalid_i  in  1  memory response valid.
- mem_rdata_i  in  32  memory read data.
- spurious_o  out  1  sticky flag: mem_rvalid_i arrived outside the RESP state.

## Operation
- FSM states:
  - IDLE: no transaction in progress.
  - ADDR: mem_req_o = 1, waiting for mem_gnt_i.
  - RESP: waiting for mem_rvalid_i.
- IDLE with any request:
  - Select the winner.
  - Register its address, we and wdata into the mem_* outputs. An instruction winner gets mem_we_o = 0 and mem_wdata_o = 0.
  - Record the owner. Go to ADDR.
- Winner selection:
  - Data wins when both ports request, unless the streak has reached MAX_DATA_STREAK; then instruction wins.
  - A single requester always wins.
- Streak counter:
  - Increments on each data selection made while instr_req_i = 1.
  - Clears on any instruction selection.
  - Clears on any data selection made while instr_req_i = 0.
  - Saturates at MAX_DATA_STREAK.
- ADDR:
  - mem_* outputs stay stable until mem_gnt_i.
  - On mem_gnt_i: the owner's gnt_o = 1 in that same cycle (combinational from mem_gnt_i and owner). Next state RESP, with mem_req_o = 0.
- RESP:
  - The owner's rvalid_o = mem_rvalid_i, combinational.
  - Both rdata_o ports are driven from mem_rdata_i at all times.
  - The non-owner's rvalid_o is 0.
  - On mem_rvalid_i, return to IDLE.
- Requests that arrive during ADDR or RESP wait; they are arbitrated in the next IDLE cycle.
- mem_rvalid_i in IDLE or ADDR: ignored, sets spurious_o, and is not forwarded to either port.
- spurious_o clears only on reset.

## Timing
- Reset values:
  - State IDLE; streak 0.
  - mem_req_o 0; mem_addr_o, mem_we_o, mem_wdata_o all 0.
  - All gnt_o and rvalid_o 0; spurious_o 0.
- Latency from req_i (in IDLE) to mem_req_o is 1 cycle.
- gnt_o arrives in the same cycle as mem_gnt_i.
- rvalid_o arrives in the same cycle as mem_rvalid_i.
- Minimum transaction is 3 cycles (IDLE, ADDR, RESP) with zero-wait memory, where rvalid comes the cycle after gnt. Peak throughput is 1 transaction per 3 cycles.
- Reset mid-transaction: the FSM returns to IDLE immediately and the outstanding response is lost. A late mem_rvalid_i after reset sets spurious_o.
- A requester that drops req_i before gnt_o violates the protocol; the arbiter still completes the latched transaction.

## Test plan
- Single fetch: instr_req_i with address 0x100; mem grants 1 cycle after mem_req_o and returns rdata 0xDEADBEEF the next cycle.
  - Required: mem_addr_o = 0x100 and mem_we_o = 0.
  - Required: instr_gnt_o and instr_rvalid_o each pulse once; instr_rdata_o = 0xDEADBEEF; the data_* outputs stay 0.
- Store: data_we_i = 0xF, address 0x2000, wdata 0x12345678.
  - Required: mem_we_o = 0xF and mem_wdata_o = 0x12345678.
  - Required: data_rvalid_o pulses once; instr_rvalid_o stays 0.
- Both ports request continuously with MAX_DATA_STREAK = 4.
  - Required grant order: D D D D I D D D D I, repeating.
- Wait states: mem_gnt_i delayed 3 cycles and mem_rvalid_i delayed 2 cycles after the grant.
  - Required: mem_addr_o is stable throughout ADDR.
  - Required: no new mem_req_o until after rvalid.
- rst_i asserted during RESP, then mem_rvalid_i 2 cycles later.
  - Required: all outputs return to reset values asynchronously.
  - Required: spurious_o = 1 and no rvalid_o is forwarded.
- mem_rvalid_i pulsed in IDLE.
  - Required: spurious_o sets and stays set; normal transactions afterward are unaffected.
